// File: rtl/wb_to_apb_bridge_pkg.sv
// Shared types and bus geometry for the Wishbone-to-APB bridge.
// The slave register file imports this package as well.
package wb2apb_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int GRANULE    = 8;
    localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // A timeout of 0 still needs a one-bit counter so the ports stay legal.
    function automatic int cnt_width(input int unsigned limit);
        int w;
        w = (limit == 0) ? 1 : $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_to_apb_bridge_if.sv
// Bus bundles for the bridge: classic Wishbone on the upstream side, APB4 downstream.
// Signal names are written from the bridge's point of view (_i into it, _o out of it).
interface wb_bus_if
    import wb2apb_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH,
    parameter int SW = SEL_WIDTH
);
    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_i;
    logic          we_i;
    logic          stb_i;
    logic          cyc_i;
    logic          ack_o;
    logic          err_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
        output dat_o, ack_o, err_o
    );
endinterface

interface apb_bus_if
    import wb2apb_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH,
    parameter int SW = SEL_WIDTH
);
    logic [AW-1:0] paddr_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    modport master (
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/wb_to_apb_bridge_timeout.sv
// Saturating count of APB wait states; expired_o flags the wait cycle that reaches the limit,
// so the bridge can leave ACCESS on that same edge.
module apb_timeout_counter
    import wb2apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW:0] LIMIT = (CW+1)'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_inc[CW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && count_en_i && (cnt_inc >= LIMIT);

endmodule

// File: rtl/wb_to_apb_bridge.sv
// Replays each classic Wishbone single transfer as one APB4 SETUP/ACCESS transfer and
// returns the APB data and completion status as ack_o or err_o.
//
//  state   | meaning
//  IDLE    | waiting for cyc&stb, request captured on acceptance
//  SETUP   | APB setup phase (psel=1, penable=0)
//  ACCESS  | APB access phase, waiting for pready or timeout
//  RESPOND | ack/err held until the master drops stb
module wb_to_apb_bridge
    import wb2apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    wb_bus_if.slave   wb,
    apb_bus_if.master apb
);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SEL_WIDTH-1:0]  pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  abort_q, abort_d;
    logic                  cnt_en;
    logic                  cnt_clear;
    logic                  expired;

    assign cnt_en    = (state_q == ACCESS) && !apb.pready_i;
    assign cnt_clear = (state_q != ACCESS);

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (cnt_clear),
        .count_en_i (cnt_en),
        .expired_o  (expired)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        dat_d     = dat_q;
        ack_d     = ack_q;
        err_d     = err_q;
        abort_d   = abort_q;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (wb.cyc_i && wb.stb_i) begin
                    state_d   = SETUP;
                    paddr_d   = wb.adr_i;
                    pwrite_d  = wb.we_i;
                    pwdata_d  = wb.we_i ? wb.dat_i : '0;
                    pstrb_d   = wb.we_i ? wb.sel_i : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                if (!wb.cyc_i) abort_d = 1'b1;
            end
            ACCESS: begin
                if (!wb.cyc_i) abort_d = 1'b1;
                if (apb.pready_i || expired) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    // An abandoned cycle still lets APB finish, but nobody is waiting for the answer.
                    if (abort_q || !wb.cyc_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESPOND;
                        if (!apb.pready_i || apb.pslverr_i) begin
                            err_d = 1'b1;
                            dat_d = '0;
                        end else begin
                            ack_d = 1'b1;
                            dat_d = pwrite_q ? '0 : apb.prdata_i;
                        end
                    end
                end
            end
            RESPOND: begin
                if (!wb.stb_i) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    dat_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
        end
    end

    assign apb.paddr_o   = paddr_q;
    assign apb.psel_o    = psel_q;
    assign apb.penable_o = penable_q;
    assign apb.pwrite_o  = pwrite_q;
    assign apb.pwdata_o  = pwdata_q;
    assign apb.pstrb_o   = pstrb_q;
    assign wb.dat_o      = dat_q;
    assign wb.ack_o      = ack_q;
    assign wb.err_o      = err_q;

endmodule

// File: tb/tb_wb_to_apb_bridge.sv
// Self-checking bench for wb_to_apb_bridge (timeout set to 4 so the limit is reachable).
module tb_wb_to_apb_bridge;
    import wb2apb_pkg::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_bus_if  wb ();
    apb_bus_if apb ();

    wb_to_apb_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb),
        .apb   (apb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          term_c;
        int          acc;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        setup_psel;
        logic        setup_pen;
        logic [15:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        unstable;
        logic        both;
        logic        apb_at_term;
        logic        held;
        logic        post_term;
        logic        post_psel;
    } obs_t;

    // Drives one Wishbone transfer from a negedge and acts as the APB slave; records what it saw.
    task automatic run_txn(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int waits, input logic slverr,
                           input logic [31:0] rdata, output obs_t o);
        int acc;
        o.term_c = -1; o.acc = 0; o.ack = 0; o.err = 0; o.dat = '0;
        o.setup_psel = 0; o.setup_pen = 0; o.paddr = '0; o.pwrite = 0; o.pwdata = '0;
        o.pstrb = '0; o.unstable = 0; o.both = 0; o.apb_at_term = 0; o.held = 0;
        o.post_term = 0; o.post_psel = 0;
        wb.adr_i = adr; wb.dat_i = dat; wb.sel_i = sel; wb.we_i = we;
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1;
        acc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (wb.ack_o && wb.err_o) o.both = 1;
            if (c == 1) begin
                o.setup_psel = apb.psel_o; o.setup_pen = apb.penable_o;
                o.paddr = apb.paddr_o; o.pwrite = apb.pwrite_o;
                o.pwdata = apb.pwdata_o; o.pstrb = apb.pstrb_o;
            end
            if (apb.psel_o && apb.penable_o) begin
                acc++;
                if (apb.paddr_o !== o.paddr || apb.pwrite_o !== o.pwrite ||
                    apb.pwdata_o !== o.pwdata || apb.pstrb_o !== o.pstrb) o.unstable = 1;
            end
            if (wb.ack_o || wb.err_o) begin
                o.term_c = c; o.ack = wb.ack_o; o.err = wb.err_o; o.dat = wb.dat_o;
                o.apb_at_term = apb.psel_o | apb.penable_o;
                break;
            end
            apb.pready_i  = apb.psel_o && apb.penable_o && (acc == waits + 1);
            apb.pslverr_i = apb.pready_i & slverr;
            apb.prdata_i  = apb.pready_i ? rdata : $urandom;
        end
        o.acc = acc;
        apb.pready_i = 1'b0; apb.pslverr_i = 1'b0;
        if (o.term_c > 0) begin
            @(posedge clk); @(negedge clk);
            o.held = (wb.ack_o === o.ack) && (wb.err_o === o.err) && (wb.dat_o === o.dat);
        end
        wb.stb_i = 1'b0; wb.cyc_i = 1'b0;
        @(posedge clk); @(negedge clk);
        o.post_term = wb.ack_o | wb.err_o;
        o.post_psel = apb.psel_o;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wb.ack_o, wb.err_o, wb.dat_o, apb.paddr_o, apb.psel_o, apb.penable_o,
             apb.pwrite_o, apb.pwdata_o, apb.pstrb_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b err=%b psel=%b pen=%b paddr=%h want all zero",
                     wb.ack_o, wb.err_o, apb.psel_o, apb.penable_o, apb.paddr_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        run_txn(1'b1, 16'h0004, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 32'h0, o);
        checks++;
        if ({o.setup_psel, o.setup_pen} !== 2'b10) begin
            errors++; $display("FAIL wr_setup got psel/pen=%b%b want 10", o.setup_psel, o.setup_pen);
        end
        checks++;
        if ({o.paddr, o.pwrite, o.pwdata, o.pstrb} !== {16'h0004, 1'b1, 32'hDEADBEEF, 4'b0011}) begin
            errors++; $display("FAIL wr_fields got %h %b %h %b want 0004 1 deadbeef 0011",
                               o.paddr, o.pwrite, o.pwdata, o.pstrb);
        end
        checks++;
        if (o.term_c !== 3 || o.ack !== 1'b1 || o.err !== 1'b0) begin
            errors++; $display("FAIL wr_ack got cycle=%0d ack=%b err=%b want cycle=3 ack=1 err=0",
                               o.term_c, o.ack, o.err);
        end
        checks++;
        if (!o.held || o.post_term !== 1'b0) begin
            errors++; $display("FAIL wr_hold got held=%b after_drop=%b want 1 0", o.held, o.post_term);
        end
    endtask

    task automatic test_read_waits();
        obs_t o;
        run_txn(1'b0, 16'h0010, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h12345678, o);
        checks++;
        if (o.acc !== 4 || o.pstrb !== 4'b0000 || o.pwdata !== 32'h0) begin
            errors++; $display("FAIL rd_access got pen_cycles=%0d pstrb=%b pwdata=%h want 4 0000 0",
                               o.acc, o.pstrb, o.pwdata);
        end
        checks++;
        if (o.ack !== 1'b1 || o.err !== 1'b0 || o.dat !== 32'h12345678 || o.term_c !== 6) begin
            errors++; $display("FAIL rd_data got ack=%b err=%b dat=%h cycle=%0d want 1 0 12345678 6",
                               o.ack, o.err, o.dat, o.term_c);
        end
    endtask

    task automatic test_slverr();
        obs_t o;
        run_txn(1'b0, 16'h0BAD, 32'h0, 4'hF, 1, 1'b1, 32'hCAFEF00D, o);
        checks++;
        if (o.err !== 1'b1 || o.ack !== 1'b0 || o.dat !== 32'h0 || !o.held) begin
            errors++; $display("FAIL slverr got err=%b ack=%b dat=%h held=%b want 1 0 0 1",
                               o.err, o.ack, o.dat, o.held);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 16'h0020, 32'h0, 4'hF, 1000, 1'b0, 32'h0, o);
        checks++;
        if (o.acc !== T || o.apb_at_term !== 1'b0 || o.term_c !== 2 + T) begin
            errors++; $display("FAIL timeout_apb got pen_cycles=%0d apb_at_term=%b cycle=%0d want %0d 0 %0d",
                               o.acc, o.apb_at_term, o.term_c, T, 2 + T);
        end
        checks++;
        if (o.err !== 1'b1 || o.ack !== 1'b0 || o.dat !== 32'h0) begin
            errors++; $display("FAIL timeout_err got err=%b ack=%b dat=%h want 1 0 0", o.err, o.ack, o.dat);
        end
        run_txn(1'b1, 16'h0024, 32'h0000_5A5A, 4'b1111, 1, 1'b0, 32'h0, o);
        checks++;
        if (o.ack !== 1'b1 || o.err !== 1'b0 || o.term_c !== 4) begin
            errors++; $display("FAIL timeout_next got ack=%b err=%b cycle=%0d want 1 0 4", o.ack, o.err, o.term_c);
        end
    endtask

    task automatic test_cyc_drop();
        obs_t o;
        int acc = 0;
        logic seen = 1'b0;
        wb.adr_i = 16'h0030; wb.dat_i = '0; wb.sel_i = 4'hF; wb.we_i = 1'b0;
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (wb.ack_o || wb.err_o) seen = 1'b1;
            if (apb.psel_o && apb.penable_o) acc++;
            if (c == 2) begin wb.cyc_i = 1'b0; wb.stb_i = 1'b0; end
            apb.pready_i  = apb.psel_o && apb.penable_o && (acc == 3);
            apb.pslverr_i = 1'b0;
            apb.prdata_i  = 32'h7777_7777;
        end
        apb.pready_i = 1'b0;
        checks++;
        if (acc !== 3 || seen !== 1'b0 || apb.psel_o !== 1'b0) begin
            errors++; $display("FAIL cyc_drop got pen_cycles=%0d term_seen=%b psel=%b want 3 0 0",
                               acc, seen, apb.psel_o);
        end
        run_txn(1'b0, 16'h0034, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_0001, o);
        checks++;
        if (o.ack !== 1'b1 || o.term_c !== 3 || o.dat !== 32'hA5A5_0001) begin
            errors++; $display("FAIL cyc_drop_next got ack=%b cycle=%0d dat=%h want 1 3 a5a50001",
                               o.ack, o.term_c, o.dat);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        wb.adr_i = 16'h0040; wb.dat_i = 32'h1; wb.sel_i = 4'hF; wb.we_i = 1'b1;
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({apb.psel_o, apb.penable_o, wb.ack_o, wb.err_o, apb.paddr_o, apb.pwdata_o} !== '0) begin
            errors++; $display("FAIL reset_mid got psel=%b pen=%b ack=%b err=%b want all 0",
                               apb.psel_o, apb.penable_o, wb.ack_o, wb.err_o);
        end
        rst = 1'b0; wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
        @(posedge clk); @(negedge clk);
        run_txn(1'b0, 16'h0044, 32'h0, 4'hF, 2, 1'b0, 32'h0BADCAFE, o);
        checks++;
        if (o.ack !== 1'b1 || o.term_c !== 5 || o.dat !== 32'h0BADCAFE) begin
            errors++; $display("FAIL reset_mid_next got ack=%b cycle=%0d dat=%h want 1 5 0badcafe",
                               o.ack, o.term_c, o.dat);
        end
    endtask

    task automatic test_stb_no_cyc();
        logic seen = 1'b0;
        wb.stb_i = 1'b1; wb.cyc_i = 1'b0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (apb.psel_o || wb.ack_o || wb.err_o) seen = 1'b1;
        end
        wb.stb_i = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL stb_no_cyc got activity=%b want 0", seen);
        end
    endtask

    // Expected outcome comes from the transfer rules: wait count vs. limit, then slave error, then data.
    task automatic test_random();
        obs_t o;
        logic we, slverr, exp_err;
        logic [15:0] adr;
        logic [31:0] dat, rdata, exp_dat;
        logic [3:0] sel;
        int waits, exp_acc;
        for (int i = 0; i < 40; i++) begin
            we = 1'(($urandom_range(0, 1)));
            adr = 16'($urandom); dat = $urandom; rdata = $urandom; sel = 4'($urandom);
            waits = $urandom_range(0, 6);
            slverr = ($urandom_range(0, 3) == 0);
            exp_acc = (waits >= T) ? T : waits + 1;
            exp_err = (waits >= T) || slverr;
            exp_dat = (!exp_err && !we) ? rdata : 32'h0;
            run_txn(we, adr, dat, sel, waits, slverr, rdata, o);
            checks++;
            if ({o.paddr, o.pwrite, o.pwdata, o.pstrb} !== {adr, we, (we ? dat : 32'h0), (we ? sel : 4'h0)}) begin
                errors++; $display("FAIL rnd_fields[%0d] got %h %b %h %b want %h %b", i,
                                   o.paddr, o.pwrite, o.pwdata, o.pstrb, adr, we);
            end
            checks++;
            if (o.term_c !== 2 + exp_acc || o.acc !== exp_acc) begin
                errors++; $display("FAIL rnd_timing[%0d] got cycle=%0d pen_cycles=%0d want %0d %0d", i,
                                   o.term_c, o.acc, 2 + exp_acc, exp_acc);
            end
            checks++;
            if ({o.ack, o.err} !== {!exp_err, exp_err} || o.dat !== exp_dat) begin
                errors++; $display("FAIL rnd_resp[%0d] got ack=%b err=%b dat=%h want %b %b %h", i,
                                   o.ack, o.err, o.dat, !exp_err, exp_err, exp_dat);
            end
            checks++;
            if (o.unstable || o.both || !o.held || o.post_term || o.post_psel || o.apb_at_term) begin
                errors++; $display("FAIL rnd_proto[%0d] got unstable=%b both=%b held=%b post=%b%b at_term=%b", i,
                                   o.unstable, o.both, o.held, o.post_term, o.post_psel, o.apb_at_term);
            end
        end
    endtask

    initial begin
        wb.adr_i = '0; wb.dat_i = '0; wb.sel_i = '0; wb.we_i = 1'b0;
        wb.stb_i = 1'b0; wb.cyc_i = 1'b0;
        apb.prdata_i = '0; apb.pready_i = 1'b0; apb.pslverr_i = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_cyc_drop();
        test_reset_mid();
        test_stb_no_cyc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
